// File: rtl/tt_um_ks_adder_stream.sv
// Streaming nibble-serial Kogge-Stone adder/subtractor Tiny Tapeout tile.
// Define KS_PIPE_EN to split the prefix tree with a register (adds state ADD2).
module tt_um_ks_adder_stream #(
  parameter int WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int N = WIDTH / 4;
  localparam int L = $clog2(WIDTH);
  localparam logic [3:0] LAST = 4'(N - 1);

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd3;
`ifdef KS_PIPE_EN
  localparam logic [1:0] ST_ADD2 = 2'd2;
  localparam logic [1:0] ST_RES  = ST_ADD2;
  localparam int S1 = (L + 1) / 2;
`else
  localparam logic [1:0] ST_RES  = ST_ADD;
  localparam int S1 = L;
`endif

  logic [1:0]       state_q, state_d;
  logic [3:0]       ldCnt_q, ldCnt_d;
  logic [3:0]       outCnt_q, outCnt_d;
  logic [WIDTH-1:0] opA_q, opB_q;
  logic             sub_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q, ovf_q, zero_q;

  logic validIn, subIn, readyIn;
  logic loadFire;
  logic unusedIn;

  assign validIn  = uio_in[0];
  assign subIn    = uio_in[1];
  assign readyIn  = uio_in[2];
  assign unusedIn = ^uio_in[7:3];

  // One Kogge-Stone combine level at span d; packed as {generate, propagate}.
  function automatic logic [2*WIDTH-1:0] ksLevel(input logic [WIDTH-1:0] g,
                                                 input logic [WIDTH-1:0] p,
                                                 input int d);
    logic [WIDTH-1:0] gOut, pOut;
    gOut = g;
    pOut = p;
    for (int i = d; i < WIDTH; i++) begin
      gOut[i] = g[i] | (p[i] & g[i-d]);
      pOut[i] = p[i] & p[i-d];
    end
    return {gOut, pOut};
  endfunction

  logic [WIDTH-1:0]   bEff, p0, gen0;
  logic [2*WIDTH-1:0] gp1;
  logic [WIDTH-1:0]   gFinal, p0Sum;
  logic               cinSum;
  logic [WIDTH-1:0]   sum;
  logic               carryOut, carryMsb;

  assign bEff = sub_q ? ~opB_q : opB_q;
  assign p0   = opA_q ^ bEff;
  assign gen0 = opA_q & bEff;

  // Carry-in is folded into bit 0's generate so the prefix yields true carries.
  always_comb begin
    gp1 = {gen0[WIDTH-1:1], gen0[0] | (p0[0] & sub_q), p0};
    for (int k = 1; k <= S1; k++) begin
      gp1 = ksLevel(gp1[2*WIDTH-1:WIDTH], gp1[WIDTH-1:0], 1 << (k - 1));
    end
  end

`ifdef KS_PIPE_EN
  logic [WIDTH-1:0]   gPipe_q, pPipe_q, p0Pipe_q;
  logic               cinPipe_q;
  logic [2*WIDTH-1:0] gp2;

  always_comb begin
    gp2 = {gPipe_q, pPipe_q};
    for (int k = S1 + 1; k <= L; k++) begin
      gp2 = ksLevel(gp2[2*WIDTH-1:WIDTH], gp2[WIDTH-1:0], 1 << (k - 1));
    end
  end

  assign gFinal = gp2[2*WIDTH-1:WIDTH];
  assign p0Sum  = p0Pipe_q;
  assign cinSum = cinPipe_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gPipe_q   <= '0;
      pPipe_q   <= '0;
      p0Pipe_q  <= '0;
      cinPipe_q <= 1'b0;
    end else if (ena && state_q == ST_ADD) begin
      gPipe_q   <= gp1[2*WIDTH-1:WIDTH];
      pPipe_q   <= gp1[WIDTH-1:0];
      p0Pipe_q  <= p0;
      cinPipe_q <= sub_q;
    end
  end
`else
  assign gFinal = gp1[2*WIDTH-1:WIDTH];
  assign p0Sum  = p0;
  assign cinSum = sub_q;
`endif

  assign sum      = p0Sum ^ {gFinal[WIDTH-2:0], cinSum};
  assign carryOut = gFinal[WIDTH-1];
  assign carryMsb = gFinal[WIDTH-2];

  always_comb begin
    state_d  = state_q;
    ldCnt_d  = ldCnt_q;
    outCnt_d = outCnt_q;
    loadFire = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (validIn) begin
          loadFire = 1'b1;
          if (ldCnt_q == LAST) begin
            ldCnt_d = '0;
            state_d = ST_ADD;
          end else begin
            ldCnt_d = ldCnt_q + 4'd1;
          end
        end
      end
`ifdef KS_PIPE_EN
      ST_ADD:  state_d = ST_ADD2;
      ST_ADD2: state_d = ST_OUT;
`else
      ST_ADD:  state_d = ST_OUT;
`endif
      ST_OUT: begin
        if (readyIn) begin
          if (outCnt_q == LAST) begin
            outCnt_d = '0;
            state_d  = ST_LOAD;
          end else begin
            outCnt_d = outCnt_q + 4'd1;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_LOAD;
      ldCnt_q  <= '0;
      outCnt_q <= '0;
      opA_q    <= '0;
      opB_q    <= '0;
      sub_q    <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else if (ena) begin
      state_q  <= state_d;
      ldCnt_q  <= ldCnt_d;
      outCnt_q <= outCnt_d;
      if (loadFire) begin
        opA_q[{ldCnt_q, 2'b00} +: 4] <= ui_in[3:0];
        opB_q[{ldCnt_q, 2'b00} +: 4] <= ui_in[7:4];
        if (ldCnt_q == 4'd0) sub_q <= subIn;
      end
      if (state_q == ST_RES) begin
        result_q <= sum;
        carry_q  <= carryOut;
        ovf_q    <= carryMsb ^ carryOut;
        zero_q   <= (sum == '0);
      end
    end
  end

  logic       inReady, outValid;
  logic [3:0] outNib;

  assign inReady  = (state_q == ST_LOAD);
  assign outValid = (state_q == ST_OUT);
  assign outNib   = result_q[{outCnt_q, 2'b00} +: 4];

  // Result and flags are only presented while a result is actually on offer.
  assign uo_out  = outValid ? {outCnt_q, outNib} : 8'h00;
  assign uio_out = {zero_q & outValid, ovf_q & outValid, carry_q & outValid,
                    outValid, inReady, 3'b000};
  assign uio_oe  = 8'b1111_1000;

endmodule

// File: tb/tb_tt_um_ks_adder_stream.sv
// Scoreboard bench for tt_um_ks_adder_stream: directed vectors at WIDTH=16,
// plus single-vector checks of WIDTH=8 and WIDTH=64 instances.
module tb_tt_um_ks_adder_stream;

  localparam int N = 4;
`ifdef KS_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n, ena;
  logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;
  logic validIn, subIn, readyIn;
  logic [7:0] ui8, uio8, uo8, uioOut8, uioOe8;
  logic [7:0] ui64, uio64, uo64, uioOut64, uioOe64;

  assign uio_in = {5'b10101, readyIn, subIn, validIn};

  always #5 clk = ~clk;

  tt_um_ks_adder_stream #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe));

  tt_um_ks_adder_stream #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui8), .uio_in(uio8),
    .uo_out(uo8), .uio_out(uioOut8), .uio_oe(uioOe8));

  tt_um_ks_adder_stream #(.WIDTH(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui64), .uio_in(uio64),
    .uo_out(uo64), .uio_out(uioOut64), .uio_oe(uioOe64));

  typedef struct packed {
    logic [7:0] uo;
    logic [7:0] uio;
  } expT;

  expT expQ[$];
  int  checkCnt = 0;
  int  passCnt  = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCnt++;
    if (actual === expected) passCnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic timeoutFail(input string name);
    checkCnt++;
    $display("[TB] FAIL %s: timed out, expected a DUT response", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every nibble the DUT hands over is checked against the scoreboard.
  initial begin
    expT e;
    forever begin
      @(negedge clk);
      if (rst_n && ena && uio_out[4] && readyIn) begin
        if (expQ.size() == 0) begin
          checkCnt++;
          $display("[TB] FAIL unexpected output: got 0x%0h, expected no output",
                   {uo_out, uio_out});
        end else begin
          e = expQ.pop_front();
          checkOutput("result nibble", {uo_out, uio_out}, {e.uo, e.uio});
        end
      end
    end
  end

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                               input logic sub, input logic [15:0] res,
                               input logic c, input logic v, input logic z,
                               input int gap);
    logic wasReady;
    int   guard;
    int   lat;
    for (int i = 0; i < N; i++)
      expQ.push_back({4'(i), res[4*i +: 4], z, v, c, 1'b1, 1'b0, 3'b000});
    for (int i = 0; i < N; i++) begin
      if (i > 0) begin
        repeat (gap) begin
          validIn = 1'b0;
          ui_in   = 8'hFF;
          tick();
        end
      end
      ui_in   = {b[4*i +: 4], a[4*i +: 4]};
      subIn   = (i == 0) ? sub : ~sub;
      validIn = 1'b1;
      guard   = 0;
      do begin
        wasReady = uio_out[3];
        tick();
        guard++;
      end while (!wasReady && guard < 50);
      if (!wasReady) timeoutFail("load handshake");
    end
    validIn = 1'b0;
    ui_in   = 8'h00;
    lat = 0;
    while (!uio_out[4] && lat < 20) begin
      tick();
      lat++;
    end
    checkOutput("latency", 64'(lat), 64'(LAT));
  endtask

  task automatic waitDrain();
    int guard = 0;
    while (expQ.size() != 0 && guard < 200) begin
      tick();
      guard++;
    end
    if (expQ.size() != 0) begin
      timeoutFail("output drain");
      expQ.delete();
    end
  endtask

  task automatic runWide8();
    logic [7:0] a = 8'h34;
    logic [7:0] b = 8'hCD;
    logic [7:0] r = 8'h00;
    logic [2:0] f;
    int g = 0;
    for (int i = 0; i < 2; i++) begin
      ui8  = {b[4*i +: 4], a[4*i +: 4]};
      uio8 = 8'h01;
      tick();
    end
    uio8 = 8'h00;
    while (!uioOut8[4] && g < 20) begin
      tick();
      g++;
    end
    checkOutput("w8 latency", 64'(g), 64'(LAT));
    f = uioOut8[7:5];
    for (int i = 0; i < 2; i++) begin
      r[4*i +: 4] = uo8[3:0];
      uio8 = 8'h04;
      tick();
    end
    uio8 = 8'h00;
    checkOutput("w8 sum and flags", {53'd0, f, r}, {53'd0, 3'b001, 8'h01});
  endtask

  task automatic runWide64();
    logic [63:0] a = 64'h1234_5678_9ABC_DEF0;
    logic [63:0] b = 64'h0FED_CBA9_8765_4321;
    logic [63:0] r = 64'h0;
    logic [2:0]  f;
    int g = 0;
    for (int i = 0; i < 16; i++) begin
      ui64  = {b[4*i +: 4], a[4*i +: 4]};
      uio64 = 8'h01;
      tick();
    end
    uio64 = 8'h00;
    while (!uioOut64[4] && g < 20) begin
      tick();
      g++;
    end
    checkOutput("w64 latency", 64'(g), 64'(LAT));
    f = uioOut64[7:5];
    for (int i = 0; i < 16; i++) begin
      r[4*i +: 4] = uo64[3:0];
      uio64 = 8'h04;
      tick();
    end
    uio64 = 8'h00;
    checkOutput("w64 sum", r, 64'h2222_2222_2222_2211);
    checkOutput("w64 flags", 64'(f), 64'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; ena = 1'b1;
    validIn = 1'b0; subIn = 1'b0; readyIn = 1'b0; ui_in = 8'h00;
    ui8 = 8'h00; uio8 = 8'h00; ui64 = 8'h00; uio64 = 8'h00;
    repeat (3) tick();
    checkOutput("reset uo_out", 64'(uo_out), 64'h00);
    checkOutput("reset uio_out", 64'(uio_out), 64'h08);
    checkOutput("reset uio_oe", 64'(uio_oe), 64'hF8);
    checkOutput("reset uio_oe w8", 64'(uioOe8), 64'hF8);
    checkOutput("reset uio_oe w64", 64'(uioOe64), 64'hF8);
    #2 rst_n = 1'b1;
    tick();

    $display("[TB] basic add 0x1234 + 0x0FCD");
    readyIn = 1'b1;
    applyStimulus(16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b0, 0);
    waitDrain();

    $display("[TB] carry/zero and overflow, back-to-back with load gaps");
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 0);
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 2);
    waitDrain();

    $display("[TB] subtract with sub toggling after nibble 0");
    applyStimulus(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 0);
    waitDrain();

    $display("[TB] backpressure and ena freeze");
    readyIn = 1'b0;
    applyStimulus(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 0);
    repeat (5) begin
      tick();
      checkOutput("backpressure hold", {55'd0, uo_out, uio_out[4]}, {55'd0, 8'h0E, 1'b1});
    end
    ena = 1'b0;
    readyIn = 1'b1;
    repeat (3) begin
      tick();
      checkOutput("ena freeze", {55'd0, uo_out, uio_out[4]}, {55'd0, 8'h0E, 1'b1});
    end
    ena = 1'b1;
    waitDrain();

    $display("[TB] reset during output and during partial load");
    readyIn = 1'b0;
    applyStimulus(16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b0, 0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset in OUT uo_out", 64'(uo_out), 64'h00);
    checkOutput("reset in OUT uio_out", 64'(uio_out), 64'h08);
    expQ.delete();
    #2 rst_n = 1'b1;
    tick();
    ui_in = 8'h9A;
    validIn = 1'b1;
    repeat (2) tick();
    validIn = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset in LOAD uio_out", 64'(uio_out), 64'h08);
    #2 rst_n = 1'b1;
    tick();
    readyIn = 1'b1;
    applyStimulus(16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b0, 0);
    waitDrain();

    $display("[TB] width 8 and width 64 instances");
    runWide8();
    runWide64();

    checkOutput("scoreboard empty", 64'(expQ.size()), 64'h0);
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule

// File: doc/tt_um_ks_adder_stream.md
# tt_um_ks_adder_stream

Parametrised, pipelined successor to the team's 4-bit Kogge-Stone adder tile: adds or subtracts two WIDTH-bit operands that are streamed in one nibble pair per cycle over the 8-bit Tiny Tapeout input bus. The result is streamed back out one nibble at a time with status flags. Sits as a top-level TT user tile behind the standard `tt_um_*` pin set; the 4-bit combinational adder remains the single-nibble special case.

## Interface
- `WIDTH`, 16, operand/result width in bits; multiple of 4, range 8..64; `N = WIDTH/4` nibbles.
- `clk`  in  1  tile clock; all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `ena`  in  1  tile enable; low freezes all state (no transfers).
- `ui_in`  in  8  `[3:0]` A nibble, `[7:4]` B nibble, LSB nibble first.
- `uio_in`  in  8  `[0]` `valid_in`, `[1]` `sub` (0 add, 1 A−B), `[2]` `ready_in` (result consumer ready); `[7:3]` ignored.
- `uo_out`  out  8  `[3:0]` result nibble, `[7:4]` current output nibble index (0..N−1).
- `uio_out`  out  8  `[3]` `in_ready`, `[4]` `out_valid`, `[5]` carry, `[6]` signed overflow, `[7]` zero; `[2:0]` = 0.
- `uio_oe`  out  8  constant `8'b1111_1000`.

## Operation
- FSM states: LOAD → ADD → (ADD2 if pipelined) → OUT → LOAD.
- LOAD: `in_ready`=1. Nibble pair accepted on edge with `ena & valid_in`; stored at index `ld_cnt`, `ld_cnt` increments. `sub` sampled with nibble 0 only. Acceptance of nibble N−1 → ADD.
- ADD: Kogge-Stone prefix (log2(WIDTH) levels of generate/propagate) over A and (sub ? ~B : B) with carry-in = `sub`. Sum, flags latched into result register → OUT.
- Flags: carry = bit WIDTH carry-out (for sub, 1 = no borrow); overflow = carry into MSB XOR carry-out; zero = result == 0.
- OUT: `out_valid`=1; `uo_out[3:0]` = result nibble `out_cnt`; flags stable for entire OUT. Nibble consumed on edge with `ena & ready_in`; `out_cnt` increments; consuming nibble N−1 → LOAD, counters cleared.
- `valid_in` ignored outside LOAD; `ready_in` ignored outside OUT.
- `in_ready` and `out_valid` never both 1.
- Reset (any state, any time): state LOAD, counters 0, operand/result/flag registers 0; partial transfers discarded.

## Timing
- Reset values: `uo_out`=0x00, `uio_out`=`8'b0000_1000` (`in_ready`=1, all else 0), `uio_oe`=0xF8.
- Load: N accepting edges minimum; `valid_in` gaps allowed, no timeout.
- Latency: last load edge k → `out_valid`=1 after edge k+1 (k+2 with `KS_PIPE_EN`).
- Output: one nibble per accepting edge; `ready_in` low holds nibble and index indefinitely.
- Back-to-back: after final OUT edge, `in_ready`=1 in the next cycle; a `valid_in` high on that same final edge is not accepted.
- `ena` low: no state, counter or output change regardless of handshakes.
- All outputs registered or decoded from registered state only; no combinational path from `ui_in`/`uio_in` to outputs.

## Configuration
- `KS_PIPE_EN` defined: pipeline register inserted after prefix level ceil(log2(WIDTH)/2); state ADD2 added; compute latency 2 cycles.
- Undefined: full prefix tree in one cycle; ADD → OUT directly; latency 1 cycle.
- Functional results identical either way; only latency differs.

## Test plan
- WIDTH=16, add 0x1234 + 0x0FCD, ready_in held 1 → nibbles 1,0,2,2 (0x2201) at indices 0..3; carry=0, ovf=0, zero=0.
- Add 0xFFFF + 0x0001 → 0x0000, carry=1, ovf=0, zero=1; 0x7FFF + 0x0001 → 0x8000, carry=0, ovf=1.
- Sub 0x0005 − 0x0007 → 0xFFFE, carry=0 (borrow), ovf=0; `sub` toggled during nibbles 1..3 has no effect.
- Backpressure: ready_in low 5 cycles in OUT → index 0, nibble 0xE, out_valid=1 held; valid_in gaps in LOAD delay but do not corrupt the result.
- rst_n pulsed low after 2 load nibbles → outputs to reset values immediately; next 4 fresh nibbles give the correct sum.
- Latency: edges from last load to out_valid = 1 without `KS_PIPE_EN`, 2 with; repeat first case at WIDTH=8 and WIDTH=64.
